// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the single-outstanding instruction fetch unit.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_inc4.sv
// 32-bit combinational +4; wraps modulo 2^32.
module pc_inc4
    import pc_fetch_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = a + PC_INC;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: one request in flight, one instruction held for decode,
// redirects squash whatever is in flight or held.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        drop;
    logic [31:0] pc_next_seq;
    logic [31:0] req_pc_plus4;
    logic [31:0] redirect_aligned;
    logic        accept;

    pc_inc4 u_inc_pc  (.a(pc),     .y(pc_next_seq));
    pc_inc4 u_inc_req (.a(req_pc), .y(req_pc_plus4));

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    // Gated by reset so nothing is requested while reset is held.
    assign imem_req_valid   = (state == FETCH) && !reset;
    assign imem_req_addr    = pc;
    assign accept           = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            req_pc        <= 32'h0;
            drop          <= 1'b0;
            inst_valid    <= 1'b0;
            inst_data     <= 32'h0;
            inst_pc       <= 32'h0;
            inst_pc_plus4 <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        req_pc <= pc;
                        state  <= WAIT;
                        drop   <= redirect_valid;
                    end
                    if (redirect_valid)
                        pc <= redirect_aligned;
                    else if (accept)
                        pc <= pc_next_seq;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                        // A same-cycle response is the squashed one.
                        if (imem_rsp_valid) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            inst_valid    <= 1'b1;
                            inst_data     <= imem_rsp_data;
                            inst_pc       <= req_pc;
                            inst_pc_plus4 <= req_pc_plus4;
                            state         <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (redirect_valid) begin
                        pc         <= redirect_aligned;
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state      <= FETCH;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset; asynchronous and active-high.
REQ-004 imem_req_valid  output  1  a fetch request is presented.
REQ-005 imem_req_addr  output  32  word address of the request; it SHALL equal the current PC.
REQ-006 imem_req_ready  input  1  instruction memory accepts the request this cycle.
REQ-007 imem_rsp_valid  input  1  instruction memory returns data this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  a fetched instruction is held for decode.
REQ-010 inst_data  output  32  held instruction.
REQ-011 inst_pc  output  32  address the held instruction was fetched from.
REQ-012 inst_pc_plus4  output  32  inst_pc + 4, for link and branch-base use.
REQ-013 inst_ready  input  1  decode consumes the held instruction this cycle.
REQ-014 redirect_valid  input  1  branch or jump taken; the next fetch SHALL come from redirect_pc.
REQ-015 redirect_pc  input  32  redirect target.

Function
REQ-016 FSM states SHALL be FETCH, WAIT and FULL; FETCH is the reset state.
REQ-017 FETCH: imem_req_valid=1; on imem_req_valid && imem_req_ready, latch req_pc <= PC, set PC <= PC+4, and go to WAIT.
REQ-018 WAIT: imem_req_valid=0; on imem_rsp_valid, register data, inst_pc <= req_pc, inst_pc_plus4 <= req_pc+4, and go to FULL.
REQ-019 FULL: inst_valid=1; on inst_ready, clear inst_valid and go to FETCH.
REQ-020 At most one request SHALL be outstanding; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-021 Response-to-inst_valid latency SHALL be exactly one cycle; inst_data/inst_pc SHALL stay stable while inst_valid=1 && inst_ready=0.
REQ-022 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL yield 32'h0000_0000.
REQ-023 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into PC.
REQ-024 Redirect in FETCH without request acceptance: PC <= redirect_pc, remain in FETCH.
REQ-025 Redirect in the same cycle a request is accepted: PC <= redirect_pc, go to WAIT with drop flag set.
REQ-026 Redirect in WAIT: PC <= redirect_pc, set drop flag; a response arriving in the same or a later cycle SHALL be discarded, then go to FETCH.
REQ-027 While the drop flag is set, a discarded response SHALL NOT assert inst_valid; the drop flag SHALL clear on that response.
REQ-028 Redirect in FULL: discard the held instruction (inst_valid=0 next cycle), PC <= redirect_pc, go to FETCH; a simultaneous inst_ready SHALL still count as consumed.
REQ-029 Redirect SHALL take priority over every other same-cycle PC update.

Reset
REQ-030 While reset=1: state=FETCH, PC=RESET_PC, drop flag=0, inst_valid=0, inst_data=0, inst_pc=0, inst_pc_plus4=0.
REQ-031 imem_req_valid SHALL be 0 while reset=1 and SHALL assert in the first cycle after deassertion with imem_req_addr=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response after reset SHALL be ignored.

Structure
REQ-033 Shared package pc_fetch_pkg SHALL hold the state enum, the PC_INC=4 constant and the default RESET_PC.
REQ-034 One sub-module, pc_inc4 (32-bit combinational +4), SHALL be instantiated twice: once for next-PC and once for inst_pc_plus4.

Verification
REQ-035 Reset release, ready tied high, response one cycle after acceptance -> requests at 0x0, 0x4, 0x8; inst_pc_plus4 = 0x4, 0x8, 0xC.
REQ-036 inst_ready low for 5 cycles in FULL -> inst_data/inst_pc stable and no new request; the request resumes the cycle after inst_ready.
REQ-037 Redirect to 0x100 during WAIT, response 2 cycles later -> response dropped, inst_valid stays 0, next request addr=0x100.
REQ-038 Redirect to 0x203 in the same cycle as acceptance -> next request addr=0x200; the in-flight response is discarded.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first inst_pc=0xFFFFFFFC, inst_pc_plus4=0x0, second request addr=0x0.
REQ-040 Reset pulsed during WAIT, then a response arrives -> inst_valid=0 and a fresh request at RESET_PC.
